// File: rtl/div_s4_seq.sv
// Iterative signed divider: restoring division on magnitudes with sign correction, one quotient bit per clock.
// Latency WIDTH+1 clocks from start to done; a start is accepted only while idle (including the done cycle).
module div_s4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SIGN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] rem;
    logic             neg_dvd;
    logic             neg_q;
    logic             dz_r;
    logic             ov_r;
    logic             accept;
    logic [WIDTH:0]   pr_trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        neg = ~v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = SIGN;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift the next dividend bit into the partial remainder and trial-subtract; bit WIDTH is the borrow.
    assign pr_trial = {rem, dq[WIDTH-1]} - {1'b0, dvs_mag};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvd_r       <= '0;
            dvs_mag     <= '0;
            dq          <= '0;
            rem         <= '0;
            neg_dvd     <= 1'b0;
            neg_q       <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dvd_r   <= dividend;
                neg_dvd <= dividend[WIDTH-1];
                neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                dq      <= mag(dividend);
                dvs_mag <= mag(divisor);
                rem     <= '0;
                cnt     <= CW'(WIDTH - 1);
                dz_r    <= (divisor == '0);
                ov_r    <= (dividend == MOST_NEG) && (divisor == '1);
            end
            if (state == ITER) begin
                if (!pr_trial[WIDTH]) begin
                    rem <= pr_trial[WIDTH-1:0];
                    dq  <= {dq[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= {rem[WIDTH-2:0], dq[WIDTH-1]};
                    dq  <= {dq[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
            end
            if (state == SIGN) begin
                done        <= 1'b1;
                div_by_zero <= dz_r;
                overflow    <= ov_r;
                // Most-negative / -1 needs no override: the magnitude quotient wraps to MOST_NEG.
                if (dz_r) begin
                    quotient  <= '1;
                    remainder <= dvd_r;
                end else begin
                    quotient  <= neg_q   ? neg(dq)  : dq;
                    remainder <= neg_dvd ? neg(rem) : rem;
                end
            end
        end
    end

endmodule
